// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - register offsets, CTRL fields, mode codes and FSM states
package timer_counter_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_NONE   = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timerState_t;

   function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
      logic [31:0] merged;
      merged = oldVal;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[i*8 +: 8] = newVal[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - down-counting timer with one-shot/periodic modes and maskable IRQ
module timer_counter
   import timer_counter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [3:0]  BE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   timerState_t state, nextState;
   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irqFlag;

   logic        loadCount, decCount, expire, clrFlag, clrEnable;
   logic        ctrlWr, presetWr;
   logic        unusedAddr;

   assign unusedAddr = ^Addr[31:4];
   assign ctrlWr     = WE && (Addr[3:2] == REG_CTRL);
   assign presetWr   = WE && (Addr[3:2] == REG_PRESET);

   always_comb begin
      nextState = state;
      loadCount = 1'b0;
      decCount  = 1'b0;
      expire    = 1'b0;
      clrFlag   = 1'b0;
      clrEnable = 1'b0;
      case (state)
         IDLE: if (ctrl[CTRL_EN]) nextState = LOAD;
         LOAD: begin
            loadCount = 1'b1;
            nextState = CNT;
         end
         CNT: begin
            if (!ctrl[CTRL_EN]) begin
               nextState = IDLE;
            end else if (count > 32'd1) begin
               decCount = 1'b1;
            end else begin
               expire    = 1'b1;
               nextState = INT;
            end
         end
         INT: begin
            case (ctrl[CTRL_MODE_HI:CTRL_MODE_LO])
               MODE_PERIODIC: begin
                  clrFlag   = 1'b1;
                  nextState = LOAD;
               end
               MODE_ONESHOT: begin
                  clrEnable = 1'b1;
                  nextState = IDLE;
               end
               default: begin
                  clrEnable = 1'b1;
                  nextState = IDLE;
               end
            endcase
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         irqFlag <= 1'b0;
      end else begin
         state <= nextState;
         if (loadCount)     count <= preset;
         else if (decCount) count <= count - 32'd1;
         else if (expire)   count <= '0;
         // CPU write is applied after the FSM clear so it takes precedence
         if (clrEnable)          ctrl[CTRL_EN] <= 1'b0;
         if (ctrlWr && BE[0])    ctrl <= Din[3:0];
         if (presetWr)           preset <= byteMerge(preset, Din, BE);
         if (ctrlWr || presetWr || clrFlag) irqFlag <= 1'b0;
         if (expire)             irqFlag <= 1'b1;
      end
   end

   always_comb begin
      Dout = '0;
      case (Addr[3:2])
         REG_CTRL:   Dout = {28'd0, ctrl};
         REG_PRESET: Dout = preset;
         REG_COUNT:  Dout = count;
         REG_NONE:   Dout = '0;
         default:    Dout = '0;
      endcase
   end

   assign IRQ = irqFlag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed and randomized checks of timer_counter against a reference model
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [3:0]  BE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int total = 0;
   int bad   = 0;

   // reference model: phase 0 waiting, 1 reloading, 2 counting, 3 expired
   int          mPh;
   logic        mEn, mIm, mFlag;
   logic [1:0]  mMode;
   logic [31:0] mPre, mCnt;

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .BE    (BE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelStep();
      logic        wrC, wrP, nEn, nFlag;
      logic [31:0] nCnt, mask;
      int          nPh;
      if (reset) begin
         mPh = 0; mEn = 0; mIm = 0; mFlag = 0; mMode = 0; mPre = 0; mCnt = 0;
         return;
      end
      wrC   = WE && (Addr[1:0] == 2'd0);
      wrP   = WE && (Addr[1:0] == 2'd1);
      nPh   = mPh;
      nCnt  = mCnt;
      nEn   = mEn;
      nFlag = (wrC || wrP) ? 1'b0 : mFlag;
      case (mPh)
         0: if (mEn) nPh = 1;
         1: begin nCnt = mPre; nPh = 2; end
         2: begin
            if (!mEn) nPh = 0;
            else if (mCnt > 1) nCnt = mCnt - 1;
            else begin nCnt = 0; nFlag = 1; nPh = 3; end
         end
         default: begin
            if (mMode == 2'b01) begin nPh = 1; nFlag = 0; end
            else begin nPh = 0; nEn = 0; end
         end
      endcase
      if (wrC && BE[0]) begin nEn = Din[0]; mMode = Din[2:1]; mIm = Din[3]; end
      if (wrP) begin
         mask = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
         mPre = (mPre & ~mask) | (Din & mask);
      end
      mPh = nPh; mCnt = nCnt; mEn = nEn; mFlag = nFlag;
   endtask

   task automatic tick();
      modelStep();
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      Addr = {28'd0, a};
      Din  = d;
      BE   = be;
      WE   = 1'b1;
      tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      Addr = {28'd0, a};
      #1;
      v = Dout;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      reset = 1'b1; WE = 1'b0; Addr = '0; BE = '0; Din = '0;
      tick();
      tick();
      reset = 1'b0;
      rd(0, v); check("reset_ctrl", v, 32'd0);
      rd(1, v); check("reset_preset", v, 32'd0);
      rd(2, v); check("reset_count", v, 32'd0);
      check("reset_irq", {31'd0, IRQ}, 32'd0);

      // one-shot, PRESET=5
      wr(1, 32'd5, 4'hF);
      wr(0, 32'h9, 4'hF);
      tick(); tick();
      rd(2, v); check("m0_count_e2", v, 32'd5);
      for (int k = 3; k <= 7; k++) begin
         tick();
         check($sformatf("m0_irq_e%0d", k), {31'd0, IRQ}, (k == 7) ? 32'd1 : 32'd0);
      end
      rd(2, v); check("m0_count_e7", v, 32'd0);
      tick();
      rd(0, v); check("m0_ctrl_e8", v, 32'h8);
      tick(); tick();
      check("m0_irq_held", {31'd0, IRQ}, 32'd1);
      wr(0, 32'h8, 4'hF);
      check("m0_irq_cleared", {31'd0, IRQ}, 32'd0);

      // periodic, PRESET=5
      doReset();
      wr(1, 32'd5, 4'hF);
      wr(0, 32'hB, 4'hF);
      for (int k = 1; k <= 22; k++) begin
         tick();
         check($sformatf("m1_irq_e%0d", k), {31'd0, IRQ},
               (k == 7 || k == 14 || k == 21) ? 32'd1 : 32'd0);
      end

      // masked interrupt
      doReset();
      wr(1, 32'd3, 4'hF);
      wr(0, 32'h1, 4'hF);
      for (int k = 1; k <= 5; k++) tick();
      rd(2, v); check("mask_count0", v, 32'd0);
      check("mask_irq", {31'd0, IRQ}, 32'd0);
      tick();
      wr(0, 32'h8, 4'hF);
      check("mask_irq_after_im", {31'd0, IRQ}, 32'd0);
      rd(0, v); check("mask_ctrl", v, 32'h8);

      // pause at COUNT=3
      doReset();
      wr(1, 32'd10, 4'hF);
      wr(0, 32'h1, 4'hF);
      for (int k = 1; k <= 8; k++) tick();
      rd(2, v); check("pause_count_e8", v, 32'd4);
      wr(0, 32'h0, 4'hF);
      rd(2, v); check("pause_count_e9", v, 32'd3);
      for (int k = 1; k <= 4; k++) begin
         tick();
         rd(2, v); check($sformatf("pause_hold_%0d", k), v, 32'd3);
      end
      wr(2, 32'hDEAD_BEEF, 4'hF);
      rd(2, v); check("count_write_ignored", v, 32'd3);
      wr(3, 32'hFFFF_FFFF, 4'hF);
      rd(3, v); check("reg_c_reads_zero", v, 32'd0);

      // PRESET=0 expires at E3
      doReset();
      wr(1, 32'd0, 4'hF);
      wr(0, 32'h9, 4'hF);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("p0_irq_e%0d", k), {31'd0, IRQ}, (k == 3) ? 32'd1 : 32'd0);
      end

      // byte write
      doReset();
      wr(1, 32'h1234_5678, 4'hF);
      wr(1, 32'hFFFF_FFFF, 4'b0001);
      rd(1, v); check("byte_write", v, 32'h1234_56FF);

      // reset mid-count
      doReset();
      wr(1, 32'd5, 4'hF);
      wr(0, 32'h9, 4'hF);
      for (int k = 1; k <= 5; k++) tick();
      rd(2, v); check("rst_count_e5", v, 32'd2);
      doReset();
      rd(0, v); check("rst_ctrl", v, 32'd0);
      rd(1, v); check("rst_preset", v, 32'd0);
      rd(2, v); check("rst_count", v, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("rst_no_irq_%0d", k), {31'd0, IRQ}, 32'd0);
      end

      // randomized traffic against the model
      doReset();
      for (int i = 0; i < 400; i++) begin
         int op;
         op = $urandom_range(0, 39);
         if (op < 4)       wr(0, $urandom_range(0, 15), 4'($urandom_range(0, 15)));
         else if (op < 7)  wr(1, $urandom_range(0, 6), 4'($urandom_range(0, 15)));
         else if (op < 8)  wr(2'($urandom_range(2, 3)), $urandom, 4'hF);
         else if (op == 8) doReset();
         else              tick();
         check($sformatf("rnd_irq_%0d", i), {31'd0, IRQ}, {31'd0, mFlag & mIm});
         rd(2, v); check($sformatf("rnd_count_%0d", i), v, mCnt);
         if (i % 8 == 0) begin
            rd(0, v); check($sformatf("rnd_ctrl_%0d", i), v, {28'd0, mIm, mMode, mEn});
            rd(1, v); check($sformatf("rnd_preset_%0d", i), v, mPre);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
